// File: rtl/program_loader.sv
// program_loader: packs a length-prefixed byte stream into 32-bit words, writes them to program memory, then releases the core
module program_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              pm_wr_en,
    output logic [ADDR_W-1:0] pm_wr_addr,
    output logic [31:0]       pm_wr_data,
    output logic              core_hold,
    output logic              done,
    output logic              err
);
    localparam int NW = $clog2(DEPTH + 1);
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    typedef enum logic [2:0] {IDLE, LEN, COLLECT, WRITE, DONE, ERROR} state_t;

    state_t            state;
    logic [NW-1:0]     n;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       word;

    // Load sequencer; every output is set alongside the state it belongs to so all outputs stay registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            n          <= '0;
            byte_cnt   <= '0;
            word_idx   <= '0;
            word       <= '0;
            byte_ready <= 1'b0;
            pm_wr_en   <= 1'b0;
            pm_wr_addr <= '0;
            pm_wr_data <= '0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            pm_wr_en <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state      <= LEN;
                    byte_ready <= 1'b1;
                end
                LEN: if (byte_valid) begin
                    if (byte_in == 8'd0 || byte_in > DEPTH_B) begin
                        state      <= ERROR;
                        err        <= 1'b1;
                        byte_ready <= 1'b0;
                    end else begin
                        state    <= COLLECT;
                        n        <= NW'(byte_in);
                        byte_cnt <= '0;
                        word_idx <= '0;
                    end
                end
                COLLECT: if (byte_valid) begin
                    word     <= {byte_in, word[31:8]};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        state      <= WRITE;
                        byte_ready <= 1'b0;
                        pm_wr_en   <= 1'b1;
                        pm_wr_addr <= word_idx;
                        pm_wr_data <= {byte_in, word[31:8]};
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + ADDR_W'(1);
                    if (NW'(word_idx) + NW'(1) == n) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        core_hold <= 1'b0;
                    end else begin
                        state      <= COLLECT;
                        byte_ready <= 1'b1;
                    end
                end
                DONE, ERROR: if (start) begin
                    state      <= LEN;
                    done       <= 1'b0;
                    err        <= 1'b0;
                    core_hold  <= 1'b1;
                    byte_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized load scenarios checked against a memory-image model
module tb_program_loader;
  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, pm_wr_en, core_hold, done, err;
  logic [4:0]  pm_wr_addr;
  logic [31:0] pm_wr_data;
  int checks = 0;
  int errors = 0;
  logic [31:0] pm_mem [32];
  logic [31:0] model_mem [32];
  int   addr_log[$];
  int   multi = 0;
  logic prev_en = 1'b0;

  program_loader #(.ADDR_W(5), .DEPTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .pm_wr_en(pm_wr_en),
    .pm_wr_addr(pm_wr_addr), .pm_wr_data(pm_wr_data), .core_hold(core_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pm_wr_en) begin
      pm_mem[pm_wr_addr] = pm_wr_data;
      addr_log.push_back(int'(pm_wr_addr));
      if (prev_en) multi++;
    end
    prev_en = pm_wr_en;
  end

  function automatic bq_t mk_bytes(input int n, input wq_t w);
    bq_t q;
    q.push_back(8'(n));
    for (int i = 0; i < w.size(); i++)
      for (int k = 0; k < 4; k++) q.push_back(8'(w[i] >> (8 * k)));
    return q;
  endfunction

  function automatic wq_t rand_words(input int n);
    wq_t w;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    return w;
  endfunction

  task automatic send(input bq_t q, input bit rnd, input int start_at, output bit ok);
    int i = 0;
    int cyc = 0;
    while (i < q.size() && cyc < 2000) begin
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_in = q[i];
      start = (i == start_at);
      @(negedge clk);
      if (byte_valid && byte_ready) i++;
      @(posedge clk); #1;
      cyc++;
    end
    byte_valid = 1'b0;
    start = 1'b0;
    ok = (i == q.size());
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic settle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    addr_log.delete();
    multi = 0;
  endtask

  task automatic test_reset();
    for (int a = 0; a < 32; a++) begin
      pm_mem[a] = 32'hDEAD_0000 | a;
      model_mem[a] = 32'hDEAD_0000 | a;
    end
    reset = 1'b0;
    settle(2);
    reset = 1'b1;
    settle(1);
    checks++;
    if ({byte_ready, pm_wr_en, pm_wr_addr, pm_wr_data, core_hold, done, err} !== {1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_vals got rdy=%b en=%b addr=%0d data=%h hold=%b done=%b err=%b", byte_ready, pm_wr_en, pm_wr_addr, pm_wr_data, core_hold, done, err);
    end
    byte_valid = 1'b1;
    settle(2);
    byte_valid = 1'b0;
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got %b want 0", byte_ready);
    end
  endtask

  task automatic test_basic();
    bit ok;
    bq_t q = '{8'h02, 8'h13, 8'h00, 8'h10, 8'h00, 8'h33, 8'h01, 8'h20, 8'h00};
    clear_log();
    model_mem[0] = 32'h0010_0013;
    model_mem[1] = 32'h0020_0133;
    pulse_start();
    send(q, 1'b0, -1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_send timeout");
    end
    checks++;
    if (pm_wr_en !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency got en=%b done=%b want 1 0", pm_wr_en, done);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || core_hold !== 1'b0 || pm_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done=%b hold=%b en=%b want 1 0 0", done, core_hold, pm_wr_en);
    end
    checks++;
    if (addr_log.size() != 2 || addr_log[0] != 0 || addr_log[1] != 1) begin
      errors++;
      $display("FAIL basic_order got %0d writes want 2", addr_log.size());
    end
    for (int a = 0; a < 32; a++) begin
      checks++;
      if (pm_mem[a] !== model_mem[a]) begin
        errors++;
        $display("FAIL basic_mem[%0d] got %h want %h", a, pm_mem[a], model_mem[a]);
      end
    end
  endtask

  task automatic test_bad_len();
    bit ok;
    logic [7:0] lens[2] = '{8'h00, 8'h21};
    clear_log();
    for (int j = 0; j < 2; j++) begin
      pulse_start();
      send('{lens[j]}, 1'b0, -1, ok);
      checks++;
      if (!ok || err !== 1'b1 || core_hold !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL bad_len_%h got ok=%b err=%b hold=%b done=%b rdy=%b", lens[j], ok, err, core_hold, done, byte_ready);
      end
      settle(3);
      checks++;
      if (addr_log.size() != 0) begin
        errors++;
        $display("FAIL bad_len_writes got %0d want 0", addr_log.size());
      end
    end
  endtask

  task automatic test_random_valid();
    bit ok;
    wq_t w = rand_words(3);
    clear_log();
    for (int i = 0; i < 3; i++) model_mem[i] = w[i];
    pulse_start();
    checks++;
    if (err !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_restart got err=%b rdy=%b want 0 1", err, byte_ready);
    end
    send(mk_bytes(3, w), 1'b1, -1, ok);
    settle(2);
    checks++;
    if (!ok || done !== 1'b1) begin
      errors++;
      $display("FAIL rand_done got ok=%b done=%b want 1 1", ok, done);
    end
    checks++;
    if (addr_log.size() != 3 || multi != 0) begin
      errors++;
      $display("FAIL rand_pulses got %0d pulses %0d stuck want 3 0", addr_log.size(), multi);
    end
    for (int a = 0; a < 32; a++) begin
      checks++;
      if (pm_mem[a] !== model_mem[a]) begin
        errors++;
        $display("FAIL rand_mem[%0d] got %h want %h", a, pm_mem[a], model_mem[a]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wq_t w = rand_words(3);
    wq_t w2 = rand_words(2);
    bq_t q = mk_bytes(3, w);
    clear_log();
    model_mem[0] = w[0];
    pulse_start();
    send(q[0:6], 1'b0, -1, ok);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({byte_ready, pm_wr_en, pm_wr_addr, pm_wr_data, core_hold, done, err} !== {1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got rdy=%b en=%b addr=%0d data=%h hold=%b done=%b err=%b", byte_ready, pm_wr_en, pm_wr_addr, pm_wr_data, core_hold, done, err);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    model_mem[0] = w2[0];
    model_mem[1] = w2[1];
    pulse_start();
    send(mk_bytes(2, w2), 1'b1, -1, ok);
    settle(2);
    checks++;
    if (!ok || done !== 1'b1 || addr_log.size() != 3 || addr_log[1] != 0 || addr_log[2] != 1) begin
      errors++;
      $display("FAIL fresh_load got ok=%b done=%b writes=%0d", ok, done, addr_log.size());
    end
    for (int a = 0; a < 32; a++) begin
      checks++;
      if (pm_mem[a] !== model_mem[a]) begin
        errors++;
        $display("FAIL mid_mem[%0d] got %h want %h", a, pm_mem[a], model_mem[a]);
      end
    end
  endtask

  task automatic test_full();
    bit ok;
    wq_t w = rand_words(32);
    clear_log();
    for (int i = 0; i < 32; i++) model_mem[i] = w[i];
    pulse_start();
    send(mk_bytes(32, w), 1'b0, -1, ok);
    settle(2);
    checks++;
    if (!ok || done !== 1'b1 || addr_log.size() != 32) begin
      errors++;
      $display("FAIL full_done got ok=%b done=%b writes=%0d want 32", ok, done, addr_log.size());
    end
    for (int a = 0; a < 32; a++) begin
      checks++;
      if (addr_log.size() > a && addr_log[a] != a) begin
        errors++;
        $display("FAIL full_order[%0d] got %0d", a, addr_log[a]);
      end
      checks++;
      if (pm_mem[a] !== model_mem[a]) begin
        errors++;
        $display("FAIL full_mem[%0d] got %h want %h", a, pm_mem[a], model_mem[a]);
      end
    end
    byte_valid = 1'b1;
    byte_in = 8'hAB;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (byte_ready !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL extra_byte got rdy=%b done=%b want 0 1", byte_ready, done);
      end
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    checks++;
    if (addr_log.size() != 32) begin
      errors++;
      $display("FAIL extra_writes got %0d want 32", addr_log.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    wq_t w = rand_words(2);
    wq_t w1 = rand_words(1);
    clear_log();
    model_mem[0] = w[0];
    model_mem[1] = w[1];
    pulse_start();
    checks++;
    if (done !== 1'b0 || core_hold !== 1'b1 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_done got done=%b hold=%b rdy=%b want 0 1 1", done, core_hold, byte_ready);
    end
    send(mk_bytes(2, w), 1'b0, 3, ok);
    settle(2);
    checks++;
    if (!ok || done !== 1'b1 || addr_log.size() != 2) begin
      errors++;
      $display("FAIL collect_start got ok=%b done=%b writes=%0d want 2", ok, done, addr_log.size());
    end
    model_mem[0] = w1[0];
    pulse_start();
    send(mk_bytes(1, w1), 1'b0, -1, ok);
    settle(2);
    checks++;
    if (!ok || done !== 1'b1 || addr_log.size() != 3 || multi != 0) begin
      errors++;
      $display("FAIL one_word got ok=%b done=%b writes=%0d", ok, done, addr_log.size());
    end
    for (int a = 0; a < 32; a++) begin
      checks++;
      if (pm_mem[a] !== model_mem[a]) begin
        errors++;
        $display("FAIL b2b_mem[%0d] got %h want %h", a, pm_mem[a], model_mem[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_len();
    test_random_valid();
    test_reset_mid();
    test_full();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
